// File: rtl/fifo_read_drainer.sv
// fifo_read_drainer
//   Read-domain consumer for the async FIFO. Pops first-word-fall-through
//   words through a 2-entry skid buffer and presents them as a valid/ready
//   stream with frame markers. Also provides a flush path and a
//   delivered-word counter.
//
// Ports
//   rclk, rrst          read clock, synchronous active-high reset
//   en                  allow popping from the FIFO
//   flush               discard buffered data and drain the FIFO
//   rdata, rempty       FIFO head word / empty flag
//   rinc                FIFO pop strobe (combinational)
//   m_data, m_valid     downstream word / valid
//   m_ready             downstream accept
//   m_last              last word of a FRAME_LEN-word frame
//   words_read          saturating count of delivered words
//   busy                engine active or a word is pending
module fifo_read_drainer #(
    parameter int DATAWIDTH = 8,
    parameter int FRAME_LEN = 4,
    parameter int CNT_WIDTH = 16
) (
    input  logic                 rclk,
    input  logic                 rrst,
    input  logic                 en,
    input  logic                 flush,
    input  logic [DATAWIDTH-1:0] rdata,
    input  logic                 rempty,
    output logic                 rinc,
    output logic [DATAWIDTH-1:0] m_data,
    output logic                 m_valid,
    input  logic                 m_ready,
    output logic                 m_last,
    output logic [CNT_WIDTH-1:0] words_read,
    output logic                 busy
);

    localparam int BW = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;
    localparam logic [BW-1:0] BEAT_LAST = BW'(FRAME_LEN - 1);

    typedef enum logic [1:0] {IDLE, RUN, FLUSH} state_t;

    state_t               state;
    logic [DATAWIDTH-1:0] buf0;   // head entry, drives m_data
    logic [DATAWIDTH-1:0] buf1;   // skid entry
    logic [1:0]           occ;
    logic [BW-1:0]        beat;

    logic pop, space, push, clear;

    assign pop   = m_valid & m_ready;
    assign space = (occ < 2'd2) | pop;

    always_comb begin
        rinc = 1'b0;
        case (state)
            RUN:     rinc = !rempty & space;
            FLUSH:   rinc = !rempty;
            default: rinc = 1'b0;
        endcase
    end

    // Only RUN stores popped words; FLUSH pops are thrown away.
    assign push = (state == RUN) & rinc;
    // The buffer is emptied on the edge that requests a flush and on every
    // edge spent in FLUSH. A pop on the requesting edge still counts.
    assign clear = flush | (state == FLUSH);

    assign m_data  = buf0;
    assign m_valid = (occ != 2'd0);
    assign m_last  = m_valid & (beat == BEAT_LAST);
    assign busy    = (state != IDLE) | m_valid;

    always_ff @(posedge rclk) begin
        if (rrst) begin
            state      <= IDLE;
            buf0       <= '0;
            buf1       <= '0;
            occ        <= 2'd0;
            beat       <= '0;
            words_read <= '0;
        end else begin
            if (flush) begin
                state <= FLUSH;
            end else begin
                case (state)
                    IDLE:    if (en) state <= RUN;
                    RUN:     if (!en) state <= IDLE;
                    FLUSH:   if (rempty) state <= IDLE;
                    default: state <= IDLE;
                endcase
            end

            if (pop && (words_read != {CNT_WIDTH{1'b1}}))
                words_read <= words_read + 1'b1;

            if (clear) begin
                occ  <= 2'd0;
                beat <= '0;
            end else begin
                if (pop)
                    beat <= (beat == BEAT_LAST) ? '0 : beat + 1'b1;

                case ({push, pop})
                    2'b01: begin
                        buf0 <= buf1;
                        occ  <= occ - 2'd1;
                    end
                    2'b10: begin
                        if (occ == 2'd0) buf0 <= rdata;
                        else             buf1 <= rdata;
                        occ <= occ + 2'd1;
                    end
                    2'b11: begin
                        // Head leaves and a new word arrives: shift the skid
                        // entry forward so ordering is preserved at occ=2.
                        if (occ == 2'd1) begin
                            buf0 <= rdata;
                        end else begin
                            buf0 <= buf1;
                            buf1 <= rdata;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_fifo_read_drainer.sv
module tb_fifo_read_drainer;

    localparam int DW  = 8;
    localparam int FL  = 4;
    localparam int CW  = 3;
    localparam int SAT = (1 << CW) - 1;

    logic          rclk = 1'b0;
    logic          rrst, en, flush, m_ready;
    logic [DW-1:0] rdata, m_data;
    logic          rempty, rinc, m_valid, m_last, busy;
    logic [CW-1:0] words_read;

    // FIFO model: fall-through head, popped by rinc at the clock edge.
    logic [DW-1:0] mem [256];
    int            wr_ptr = 0;
    int            rd_ptr = 0;
    assign rempty = (rd_ptr == wr_ptr);
    assign rdata  = mem[rd_ptr[7:0]];

    always #5 rclk = ~rclk;

    always @(posedge rclk) if (rinc && !rempty) rd_ptr <= rd_ptr + 1;

    logic rst_at_edge = 1'b0;
    always @(posedge rclk) rst_at_edge <= rrst;

    fifo_read_drainer #(.DATAWIDTH(DW), .FRAME_LEN(FL), .CNT_WIDTH(CW)) dut (
        .rclk(rclk), .rrst(rrst), .en(en), .flush(flush),
        .rdata(rdata), .rempty(rempty), .rinc(rinc),
        .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready),
        .m_last(m_last), .words_read(words_read), .busy(busy)
    );

    int n_checks = 0;
    int n_err    = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: words not yet delivered, in write order. Flushing empties it.
    logic [DW-1:0] exp_q [$];
    int            n_del  = 0;
    int            beat_m = 0;
    bit            fl_active = 0;

    int rdy_mode = 0;   // 0: always ready, 1: random, 2: fixed toggle pattern
    always begin
        @(posedge rclk);
        #1;
        case (rdy_mode)
            1:       m_ready = ($urandom_range(0, 2) != 0);
            2:       m_ready = (($time / 10) % 6 == 0) || (($time / 10) % 6 == 3) ||
                               (($time / 10) % 6 == 5);
            default: m_ready = 1'b1;
        endcase
    end

    // Monitor / scoreboard.
    initial begin : monitor
        bit            en_prev = 0;
        bit            stall_prev = 0;
        logic [DW-1:0] held_d = '0;
        logic          held_l = 1'b0;
        int            dut_words;
        forever begin
            @(negedge rclk);
            if (rst_at_edge) begin
                n_del = 0; beat_m = 0; fl_active = 0; stall_prev = 0; en_prev = 0;
                chk("rst_rinc", rinc, 0);
                chk("rst_m_valid", m_valid, 0);
                chk("rst_m_last", m_last, 0);
                chk("rst_m_data", m_data, 0);
                chk("rst_words_read", words_read, 0);
                chk("rst_busy", busy, 0);
                continue;
            end
            chk("words_read", words_read, (n_del > SAT) ? SAT : n_del);
            if (rempty) chk("underflow", rinc, 0);
            if (!m_valid) chk("last_without_valid", m_last, 0);
            if (!en_prev && !fl_active) begin
                chk("idle_rinc", rinc, 0);
                chk("idle_busy", busy, m_valid);
            end
            if (fl_active) begin
                chk("flush_m_valid", m_valid, 0);
                chk("flush_busy", busy, 1);
                if (!rempty) chk("flush_rinc", rinc, 1);
            end else begin
                dut_words = exp_q.size() - (wr_ptr - rd_ptr);
                chk("occ_max", int'(dut_words <= 2), 1);
                if (m_valid && !m_ready && dut_words == 2) chk("full_stall_rinc", rinc, 0);
                if (stall_prev) begin
                    chk("stall_valid", m_valid, 1);
                    chk("stall_data", m_data, held_d);
                    chk("stall_last", m_last, held_l);
                end
            end
            if (m_valid && m_ready && !rrst) begin
                if (exp_q.size() == 0) begin
                    chk("spurious_word", m_data, -1);
                end else begin
                    chk("m_data", m_data, exp_q.pop_front());
                    chk("m_last", m_last, int'(beat_m == FL - 1));
                    n_del++;
                    beat_m = (beat_m == FL - 1) ? 0 : beat_m + 1;
                end
            end
            stall_prev = m_valid && !m_ready && !rrst && !flush;
            held_d = m_data;
            held_l = m_last;
            if (flush) begin
                exp_q.delete();
                beat_m    = 0;
                fl_active = 1;
            end else if (fl_active && rempty) begin
                fl_active = 0;
            end
            en_prev = en;
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(posedge rclk);
        #1;
    endtask

    task automatic put(input int v);
        mem[wr_ptr[7:0]] = DW'(v);
        wr_ptr++;
        exp_q.push_back(DW'(v));
    endtask

    task automatic drain(input int budget);
        int k = 0;
        while ((exp_q.size() != 0 || !rempty) && k < budget) begin
            cyc(1);
            k++;
        end
        chk("drain_in_time", int'(k < budget), 1);
        cyc(2);
    endtask

    task automatic do_reset();
        en   = 1'b0;
        rrst = 1'b1;
        cyc(3);
        rrst = 1'b0;
        cyc(1);
    endtask

    initial begin : stim
        int k;
        rrst = 1'b1; en = 1'b0; flush = 1'b0; m_ready = 1'b1;
        // Reset held while the FIFO already holds words.
        for (int i = 0; i < 3; i++) put($urandom_range(0, 255));
        cyc(3);
        rrst = 1'b0;

        // Enable gating: nothing popped while en=0.
        cyc(20);
        chk("gated_fifo_untouched", rd_ptr, 0);
        en = 1'b1;
        drain(50);

        // Plain stream 1..5.
        do_reset();
        for (int i = 1; i <= 5; i++) put(i);
        en = 1'b1;
        drain(50);
        chk("stream_words_read", words_read, 5);

        // Back-pressure pattern with 1..8.
        do_reset();
        rdy_mode = 2;
        for (int i = 1; i <= 8; i++) put(i);
        en = 1'b1;
        drain(100);
        rdy_mode = 0;

        // Flush after two deliveries, then a fresh word starts a new frame.
        do_reset();
        for (int i = 1; i <= 8; i++) put(i);
        en = 1'b1;
        k = 0;
        while (n_del < 2 && k < 50) begin cyc(1); k++; end
        chk("flush_setup_in_time", int'(k < 50), 1);
        flush = 1'b1;
        cyc(1);
        flush = 1'b0;
        k = 0;
        while ((fl_active || !rempty) && k < 50) begin cyc(1); k++; end
        chk("flush_done_in_time", int'(k < 50), 1);
        chk("flush_count_kept", int'(words_read <= 3), 1);
        cyc(2);
        put(9);
        drain(50);

        // Counter saturation.
        do_reset();
        for (int i = 0; i < 10; i++) put(100 + i);
        en = 1'b1;
        drain(100);
        chk("sat_value", words_read, SAT);
        cyc(5);

        // Random traffic, enable toggling and random back-pressure.
        rdy_mode = 1;
        for (int c = 0; c < 300; c++) begin
            if ($urandom_range(0, 2) == 0) put($urandom_range(0, 255));
            en = ($urandom_range(0, 9) != 0);
            cyc(1);
        end
        en = 1'b1;
        drain(400);
        rdy_mode = 0;

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
